// File: rtl/purchase_entry.sv
// ============================================================================
// purchase_entry : keypad/product order initiator for the purchase manager
// Rev 1.0
// ============================================================================
`default_nettype none

module purchase_entry #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       prod_valid,
   input  logic [1:0] prod_sel,
   input  logic       enter,
   input  logic       clear,
   input  logic       apple,
   input  logic       banana,
   input  logic       carrot,
   input  logic       date,
   input  logic       error,
   output logic       buy,
   output logic [1:0] product,
   output logic [3:0] digTwo,
   output logic [3:0] digOne,
   output logic       busy,
   output logic       bad_key,
   output logic       result_valid,
   output logic [1:0] result_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_BUY   = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_dig_cnt;
   logic [CNT_W-1:0] r_tmo;

   logic             w_legal;
   logic [2:0]       w_n_items;
   logic             w_match;
   logic             w_any_resp;
   logic [CNT_W-1:0] w_tmo_next;
   logic             w_tmo_done;
   logic [1:0]       w_resp_code;

   assign w_legal    = (key_digit <= 4'd9);
   assign w_n_items  = 3'(apple) + 3'(banana) + 3'(carrot) + 3'(date);
   assign w_any_resp = (w_n_items != 3'd0) | error;
   assign w_tmo_next = r_tmo + 1'b1;
   assign w_tmo_done = (w_tmo_next == CNT_W'(TIMEOUT));

   always_comb begin
      w_match = 1'b0;
      case (product)
         2'b00:   w_match = apple;
         2'b01:   w_match = banana;
         2'b10:   w_match = carrot;
         default: w_match = date;
      endcase
   end

   // Any ambiguous or refused response is reported as refused.
   always_comb begin
      w_resp_code = 2'b11;
      if (error || (w_n_items > 3'd1))
         w_resp_code = 2'b01;
      else if (w_match)
         w_resp_code = 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_dig_cnt    <= 2'd0;
         r_tmo        <= '0;
         buy          <= 1'b0;
         product      <= 2'b00;
         digTwo       <= 4'd0;
         digOne       <= 4'd0;
         busy         <= 1'b0;
         bad_key      <= 1'b0;
         result_valid <= 1'b0;
         result_code  <= 2'b00;
      end else begin
         buy          <= 1'b0;
         bad_key      <= 1'b0;
         result_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_ENTRY: begin
               if (prod_valid)
                  product <= prod_sel;
               if (clear) begin
                  digTwo    <= 4'd0;
                  digOne    <= 4'd0;
                  r_dig_cnt <= 2'd0;
                  r_state   <= S_IDLE;
               end else if (enter) begin
                  if (r_dig_cnt != 2'd0) begin
                     r_state <= S_BUY;
                     buy     <= 1'b1;
                     busy    <= 1'b1;
                  end
               end else if (key_valid) begin
                  if (w_legal) begin
                     digTwo  <= digOne;
                     digOne  <= key_digit;
                     r_state <= S_ENTRY;
                     if (r_dig_cnt != 2'd2)
                        r_dig_cnt <= r_dig_cnt + 2'd1;
                  end else begin
                     bad_key <= 1'b1;
                  end
               end
            end
            S_BUY: begin
               r_state <= S_WAIT;
               r_tmo   <= '0;
            end
            S_WAIT: begin
               // A response on the final edge takes precedence over timeout.
               if (w_any_resp || w_tmo_done) begin
                  result_valid <= 1'b1;
                  result_code  <= w_any_resp ? w_resp_code : 2'b10;
                  digTwo       <= 4'd0;
                  digOne       <= 4'd0;
                  r_dig_cnt    <= 2'd0;
                  busy         <= 1'b0;
                  r_state      <= S_IDLE;
               end else begin
                  r_tmo <= w_tmo_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_purchase_entry.sv
// ============================================================================
// tb_purchase_entry : table-driven checks for purchase_entry (TIMEOUT = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_purchase_entry;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid, prod_valid, enter, clear;
   logic [3:0] key_digit;
   logic [1:0] prod_sel;
   logic       apple, banana, carrot, date, error;
   logic       buy, busy, bad_key, result_valid;
   logic [1:0] product, result_code;
   logic [3:0] digTwo, digOne;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   purchase_entry #(.TIMEOUT(TMO), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_digit(key_digit),
      .prod_valid(prod_valid), .prod_sel(prod_sel),
      .enter(enter), .clear(clear),
      .apple(apple), .banana(banana), .carrot(carrot), .date(date), .error(error),
      .buy(buy), .product(product), .digTwo(digTwo), .digOne(digOne),
      .busy(busy), .bad_key(bad_key),
      .result_valid(result_valid), .result_code(result_code)
   );

   // rsp = {apple, banana, carrot, date, error}
   typedef struct {
      logic        kv;
      logic [3:0]  kd;
      logic        pv;
      logic [1:0]  ps;
      logic        en;
      logic        cl;
      logic [4:0]  rsp;
      logic [15:0] exp;   // {buy,busy,bad_key,result_valid,code,digTwo,digOne,product}
   } vec_t;

   localparam int NV = 59;
   vec_t v [NV];

   function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic pv,
                               input logic [1:0] ps, input logic en, input logic cl,
                               input logic [4:0] rsp, input logic b, input logic bz,
                               input logic bk, input logic rv, input logic [1:0] cd,
                               input logic [3:0] t, input logic [3:0] o, input logic [1:0] p);
      vec_t r;
      r.kv = kv; r.kd = kd; r.pv = pv; r.ps = ps; r.en = en; r.cl = cl; r.rsp = rsp;
      r.exp = {b, bz, bk, rv, cd, t, o, p};
      return r;
   endfunction

   function automatic logic [15:0] outs();
      return {buy, busy, bad_key, result_valid, result_code, digTwo, digOne, product};
   endfunction

   task automatic drive(input logic kv, input logic [3:0] kd, input logic pv,
                        input logic [1:0] ps, input logic en, input logic cl,
                        input logic [4:0] rsp);
      key_valid = kv; key_digit = kd; prod_valid = pv; prod_sel = ps;
      enter = en; clear = cl;
      {apple, banana, carrot, date, error} = rsp;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   initial begin
      int n;
      int nbuy;
      // kv kd pv ps en cl rsp      | buy busy bad rv code d2 d1 prod
      v[0]  = mk(0,0,0,0,0,0,5'b00000, 0,0,0,0,0,0,0,0);
      v[1]  = mk(1,7,0,0,0,0,5'b00000, 0,0,0,0,0,0,7,0);
      v[2]  = mk(1,5,0,0,0,0,5'b00000, 0,0,0,0,0,7,5,0);
      v[3]  = mk(0,0,1,1,0,0,5'b00000, 0,0,0,0,0,7,5,1);
      v[4]  = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,0,7,5,1);
      v[5]  = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,0,7,5,1);
      v[6]  = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,0,7,5,1);
      v[7]  = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,0,7,5,1);
      v[8]  = mk(0,0,0,0,0,0,5'b01000, 0,0,0,1,0,0,0,1);
      v[9]  = mk(0,0,0,0,0,0,5'b00000, 0,0,0,0,0,0,0,1);
      v[10] = mk(1,4,0,0,0,0,5'b00000, 0,0,0,0,0,0,4,1);
      v[11] = mk(1,2,0,0,0,0,5'b00000, 0,0,0,0,0,4,2,1);
      v[12] = mk(0,0,1,2,0,0,5'b00000, 0,0,0,0,0,4,2,2);
      v[13] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,0,4,2,2);
      v[14] = mk(0,0,0,0,0,0,5'b00010, 0,1,0,0,0,4,2,2);
      v[15] = mk(0,0,0,0,0,0,5'b00010, 0,0,0,1,3,0,0,2);
      v[16] = mk(0,0,0,0,0,0,5'b00000, 0,0,0,0,3,0,0,2);
      v[17] = mk(1,4,0,0,0,0,5'b00000, 0,0,0,0,3,0,4,2);
      v[18] = mk(1,2,0,0,0,0,5'b00000, 0,0,0,0,3,4,2,2);
      v[19] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,3,4,2,2);
      v[20] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,3,4,2,2);
      v[21] = mk(0,0,0,0,0,0,5'b00001, 0,0,0,1,1,0,0,2);
      v[22] = mk(1,8,0,0,0,0,5'b00000, 0,0,0,0,1,0,8,2);
      v[23] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,1,0,8,2);
      v[24] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,1,0,8,2);
      v[25] = mk(0,0,0,0,0,0,5'b00100, 0,0,0,1,0,0,0,2);
      v[26] = mk(1,8,0,0,0,0,5'b00000, 0,0,0,0,0,0,8,2);
      v[27] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,0,0,8,2);
      v[28] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,0,0,8,2);
      v[29] = mk(0,0,0,0,0,0,5'b10001, 0,0,0,1,1,0,0,2);
      v[30] = mk(1,1,0,0,0,0,5'b00000, 0,0,0,0,1,0,1,2);
      v[31] = mk(1,2,0,0,0,0,5'b00000, 0,0,0,0,1,1,2,2);
      v[32] = mk(1,3,0,0,0,0,5'b00000, 0,0,0,0,1,2,3,2);
      v[33] = mk(1,12,0,0,0,0,5'b00000, 0,0,1,0,1,2,3,2);
      v[34] = mk(0,0,0,0,0,0,5'b00000, 0,0,0,0,1,2,3,2);
      v[35] = mk(0,0,0,0,0,1,5'b00000, 0,0,0,0,1,0,0,2);
      v[36] = mk(0,0,0,0,1,0,5'b00000, 0,0,0,0,1,0,0,2);
      v[37] = mk(1,9,0,0,0,0,5'b00000, 0,0,0,0,1,0,9,2);
      v[38] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,1,0,9,2);
      v[39] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,1,0,9,2);
      v[40] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,1,0,9,2);
      v[41] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,1,0,9,2);
      v[42] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,1,0,9,2);
      v[43] = mk(0,0,0,0,0,0,5'b00000, 0,0,0,1,2,0,0,2);
      v[44] = mk(1,9,0,0,0,0,5'b00000, 0,0,0,0,2,0,9,2);
      v[45] = mk(0,0,0,0,1,0,5'b00000, 1,1,0,0,2,0,9,2);
      v[46] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,2,0,9,2);
      v[47] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,2,0,9,2);
      v[48] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,2,0,9,2);
      v[49] = mk(0,0,0,0,0,0,5'b00000, 0,1,0,0,2,0,9,2);
      v[50] = mk(0,0,0,0,0,0,5'b01000, 0,0,0,1,3,0,0,2);
      v[51] = mk(1,5,0,0,0,0,5'b00000, 0,0,0,0,3,0,5,2);
      v[52] = mk(1,6,1,3,1,0,5'b00000, 1,1,0,0,3,0,5,3);
      v[53] = mk(1,1,0,0,1,1,5'b00000, 0,1,0,0,3,0,5,3);
      v[54] = mk(1,2,1,0,0,0,5'b00000, 0,1,0,0,3,0,5,3);
      v[55] = mk(0,0,0,0,0,0,5'b00010, 0,0,0,1,0,0,0,3);
      v[56] = mk(1,3,0,0,0,0,5'b00000, 0,0,0,0,0,0,3,3);
      v[57] = mk(0,0,0,0,1,1,5'b00000, 0,0,0,0,0,0,0,3);
      v[58] = mk(0,0,0,0,1,0,5'b00000, 0,0,0,0,0,0,0,3);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 5'b0);
      step();
      step();
      check("reset", outs(), 16'h0000);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(v[i].kv, v[i].kd, v[i].pv, v[i].ps, v[i].en, v[i].cl, v[i].rsp);
         step();
         check($sformatf("vec%0d", i), outs(), v[i].exp);
      end

      // Reset while waiting abandons the order; a late response is ignored.
      drive(1, 1, 1, 1, 0, 0, 5'b0); step();
      drive(0, 0, 0, 0, 1, 0, 5'b0); step();
      drive(0, 0, 0, 0, 0, 0, 5'b0); step();
      step();
      check("wait_busy", {14'd0, busy, buy}, 16'h0002);
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_mid_wait", outs(), 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 5'b10000); step();
      check("late_apple", outs(), 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 5'b0); step();
      check("late_apple_quiet", outs(), 16'h0000);

      // Timeout latency measured from the enter edge, with bounded wait.
      drive(1, 7, 0, 0, 0, 0, 5'b0); step();
      drive(0, 0, 0, 0, 1, 0, 5'b0); step();
      drive(0, 0, 0, 0, 0, 0, 5'b0);
      n = 1;
      nbuy = buy ? 1 : 0;
      while (!result_valid && n < 20) begin
         step();
         n++;
         if (buy) nbuy++;
      end
      check("tmo_latency", 16'(n), 16'(TMO + 2));
      check("tmo_code", {14'd0, result_code}, 16'h0002);
      check("buy_width", 16'(nbuy), 16'd1);
      step();
      check("rv_one_cycle", {15'd0, result_valid}, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/purchase_entry.md
Name: purchase_entry

Overview:
- Initiator side of the purchase-manager interface.
- Collects keypad BCD digits and a product selection, then issues a single-cycle buy strobe with digTwo/digOne/product held stable.
- Waits for the manager's dispense/error response and reports a classified result to the front panel.
- Sits between keypad/button debouncers and the purchase manager.

Parameters:
TIMEOUT, 16, max WAIT-state clock edges to await a response before declaring timeout (≥2)
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe: key_digit valid
key_digit  input  4  BCD digit 0-9; 10-15 illegal
prod_valid  input  1  one-cycle strobe: prod_sel valid
prod_sel  input  2  00 apple, 01 banana, 10 carrot, 11 date
enter  input  1  one-cycle request to place the order
clear  input  1  one-cycle request to clear entered digits
apple, banana, carrot, date  input  1 each  manager dispense indications
error  input  1  manager refusal indication
buy  output  1  one-cycle order strobe to manager
product  output  2  selected product, to manager
digTwo  output  4  tens digit, to manager
digOne  output  4  ones digit, to manager
busy  output  1  high in BUY and WAIT
bad_key  output  1  one-cycle pulse on illegal digit
result_valid  output  1  one-cycle pulse when an order completes
result_code  output  2  00 ok, 01 refused, 10 timeout, 11 mismatch; held until next result_valid

Behaviour:
- Reset (synchronous, rst high at edge): state IDLE; buy=0, product=00, digTwo=0, digOne=0, busy=0, bad_key=0, result_valid=0, result_code=00, digit count=0, timeout counter=0. Reset mid-WAIT abandons the order; any later response is ignored.
- States: IDLE (0 digits), ENTRY (1-2 digits), BUY, WAIT.
- Digit entry (IDLE/ENTRY):
  - Legal key_digit shifts in: digTwo<=digOne, digOne<=key_digit. Count saturates at 2; a 3rd and later digit keeps shifting (last two digits kept).
  - Illegal key_digit (>9) is not stored; bad_key pulses the next cycle.
- Product select: prod_valid loads product in IDLE/ENTRY. product is held through BUY/WAIT and retained after completion.
- clear in IDLE/ENTRY: digits=0, count=0, go to IDLE. Product is unchanged.
- Same-cycle priority in IDLE/ENTRY: clear > enter > key_valid.
  - Digit arriving with enter or clear is dropped.
  - prod_valid with enter is applied; the buy uses the new product.
- enter:
  - In ENTRY: go to BUY. buy=1 for exactly the one cycle after the edge sampling enter.
  - In IDLE (no digits): ignored.
  - One digit entered: order value 0d (digTwo=0).
- BUY → WAIT unconditionally. busy=1 from BUY entry to the result edge. digTwo/digOne/product stay stable from the buy cycle until result_valid.
- WAIT, sampled each edge, counter increments:
  - Exactly one of apple/banana/carrot/date high and matching product: code 00.
  - Exactly one high, not matching product: code 11.
  - error alone high: code 01.
  - More than one response line high, or error with any item line: code 01.
  - No response after TIMEOUT edges: code 10.
  - Response on the same edge the counter reaches TIMEOUT: the response wins.
- Completion: result_valid pulses one cycle, result_code updates, digits and count go to 0, state IDLE.
- Outside WAIT: response lines are ignored. In BUY/WAIT: key_valid, prod_valid, enter and clear are ignored.

Test Plan:
- Reset then keys 7,5, prod 01, enter → buy high exactly 1 cycle; digTwo=7, digOne=5, product=01 stable; banana 3 cycles later → result_valid one cycle, code 00, digits 0.
- Keys 4,2, prod 10, enter; manager pulses date → code 11; repeat, manager pulses error → code 01; apple+error together → code 01.
- Keys 1,2,3 → digTwo=2, digOne=3; key 12 → bad_key pulse, digits unchanged; clear → digits 0, product kept; enter in IDLE → no buy.
- Key 9, enter, no response → result_valid exactly TIMEOUT edges into WAIT, code 10; response on the final edge → code from response instead.
- enter together with key 6 and prod 11 → digit dropped, buy uses product 11; keys/enter during WAIT ignored; rst mid-WAIT → all outputs reset values, later apple ignored.
